// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Producer-side readiness tracker for the dual-issue (main + aux) pipeline.
// It is the write-side counterpart of the operand bypass network.
//
// Each destination register written by an in-flight op is recorded at DC
// issue. The entry then counts down until the result can feed the bypass
// muxes. While the entry is pending, DC stalls any consumer that reads that
// register. Long-latency MDU ops (div) do not count down. They stay pending
// until mdu_done names their destination.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   iss_en_dc / _aux              slot issues this cycle (taken when not stalled)
//   iss_rd_dc / _aux              destination register of the issuing op
//   iss_lat_dc / _aux             cycles until the result is forwardable
//                                 (0 = forwardable next cycle, nothing recorded)
//   iss_long_dc                   main op is a long-latency MDU op
//   rs{1,2}_dc / _aux             DC source registers
//   rs{1,2}_vld_dc / _aux         source is actually read from the register file
//   mdu_done, mdu_rd              MDU result is forwardable next cycle, its dest
//   flush                         pipeline redirect, squashes young entries
//   stall_dc, stall_dc_aux        DC hold requests (combinational)
//   busy_vec                      per-register pending bits from state (bit0 = 0)
//   long_busy                     an MDU op is outstanding
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int NREG      = 32,
    parameter int LAT_W     = 3,
    parameter int FLUSH_AGE = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             iss_en_dc,
    input  logic [4:0]       iss_rd_dc,
    input  logic [LAT_W-1:0] iss_lat_dc,
    input  logic             iss_long_dc,

    input  logic             iss_en_dc_aux,
    input  logic [4:0]       iss_rd_dc_aux,
    input  logic [LAT_W-1:0] iss_lat_dc_aux,

    input  logic [4:0]       rs1_dc,
    input  logic [4:0]       rs2_dc,
    input  logic             rs1_vld_dc,
    input  logic             rs2_vld_dc,
    input  logic [4:0]       rs1_dc_aux,
    input  logic [4:0]       rs2_dc_aux,
    input  logic             rs1_vld_dc_aux,
    input  logic             rs2_vld_dc_aux,

    input  logic             mdu_done,
    input  logic [4:0]       mdu_rd,

    input  logic             flush,

    output logic             stall_dc,
    output logic             stall_dc_aux,
    output logic [NREG-1:0]  busy_vec,
    output logic             long_busy
);

    // Age only needs to reach FLUSH_AGE. Once it gets there, the entry is
    // old enough to survive a flush.
    localparam int AGE_W = (FLUSH_AGE < 1) ? 1 : $clog2(FLUSH_AGE + 1);
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(FLUSH_AGE);

    // -------------------------------------------------------------------------
    // Per-register state
    // -------------------------------------------------------------------------
    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic [AGE_W-1:0] age_q [NREG];
    logic [AGE_W-1:0] age_d [NREG];
    logic [NREG-1:0]  long_q;
    logic [NREG-1:0]  long_d;

    // -------------------------------------------------------------------------
    // Pending view of the state. Only flops feed busy_vec, so it is glitch-free
    // relative to the DC inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_vec[r] = (r != 0) && ((cnt_q[r] != '0) || long_q[r]);
        end
    end

    // At most one long op is ever recorded, so an OR-reduce is exact.
    assign long_busy = |long_q;

    // -------------------------------------------------------------------------
    // Stall generation
    // -------------------------------------------------------------------------
    logic main_src_busy;
    logic aux_src_busy;
    logic main_cand;
    logic aux_raw_main;

    assign main_src_busy = (rs1_vld_dc && rs1_dc != 5'd0 && busy_vec[rs1_dc])
                        || (rs2_vld_dc && rs2_dc != 5'd0 && busy_vec[rs2_dc]);

    assign aux_src_busy  = (rs1_vld_dc_aux && rs1_dc_aux != 5'd0 && busy_vec[rs1_dc_aux])
                        || (rs2_vld_dc_aux && rs2_dc_aux != 5'd0 && busy_vec[rs2_dc_aux]);

    // This term covers a main op in the same bundle whose result the aux slot
    // cannot get in time. A zero-latency main result reaches aux through the
    // aux-from-ex bypass, so that case does not stall. A long op is never
    // forwardable in time.
    assign main_cand     = iss_en_dc && iss_rd_dc != 5'd0
                        && (iss_lat_dc != '0 || iss_long_dc);

    assign aux_raw_main  = main_cand
                        && ((rs1_vld_dc_aux && rs1_dc_aux == iss_rd_dc)
                         || (rs2_vld_dc_aux && rs2_dc_aux == iss_rd_dc));

    // The stall does not depend on whether the stalled op itself issues, so
    // there is no combinational loop through the accept logic.
    assign stall_dc     = !rst && (main_src_busy || (iss_long_dc && long_busy));
    assign stall_dc_aux = !rst && (stall_dc || aux_src_busy || aux_raw_main);

    // -------------------------------------------------------------------------
    // Issue acceptance
    // -------------------------------------------------------------------------
    logic main_take;
    logic aux_take;
    logic main_rec;
    logic aux_rec;

    assign main_take = iss_en_dc     && !stall_dc     && !flush;
    assign aux_take  = iss_en_dc_aux && !stall_dc_aux && !flush;

    // A zero-latency short op is already forwardable, so recording it would
    // only cause false stalls.
    assign main_rec  = main_take && iss_rd_dc != 5'd0
                    && (iss_lat_dc != '0 || iss_long_dc);
    assign aux_rec   = aux_take  && iss_rd_dc_aux != 5'd0
                    && iss_lat_dc_aux != '0;

    // -------------------------------------------------------------------------
    // Next-state logic. Later assignments override earlier ones. The priority
    // from lowest to highest is: countdown, flush, mdu_done, main issue,
    // aux issue. The aux slot is the younger producer, so it wins a WAW race.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every next-state variable gets a value before any branch,
        // otherwise the untaken paths would infer latches.
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
            age_d[r] = (age_q[r] == AGE_SAT) ? age_q[r] : age_q[r] + AGE_W'(1);
        end
        long_d = long_q;

        // Young entries belong to ops on the squashed path. Older entries are
        // past the redirect point and must keep counting.
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                if (age_q[r] < AGE_SAT) begin
                    cnt_d[r]  = '0;
                    long_d[r] = 1'b0;
                end
            end
        end

        // An mdu_done for an entry that was flushed or overwritten by a newer
        // producer is stale. It must not release that producer.
        if (mdu_done && long_q[mdu_rd]) begin
            long_d[mdu_rd] = 1'b0;
            cnt_d[mdu_rd]  = '0;
        end

        if (main_rec) begin
            cnt_d[iss_rd_dc]  = iss_lat_dc;
            long_d[iss_rd_dc] = iss_long_dc;
            age_d[iss_rd_dc]  = '0;
        end

        if (aux_rec) begin
            cnt_d[iss_rd_dc_aux]  = iss_lat_dc_aux;
            long_d[iss_rd_dc_aux] = 1'b0;
            age_d[iss_rd_dc_aux]  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the per-register arrays are reset explicitly. They are pending
    // state rather than storage, so stale entries after reset would stall
    // the pipeline forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
                age_q[r] <= '0;
            end
            long_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the pre-edge values.
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
                age_q[r] <= age_d[r];
            end
            long_q <= long_d;
        end
    end

    // -------------------------------------------------------------------------
    // Simulation checks
    // -------------------------------------------------------------------------
    a_one_long : assert property (@(posedge clk) disable iff (rst) $onehot0(long_q));
    a_x0_idle  : assert property (@(posedge clk) disable iff (rst) !busy_vec[0]);

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Directed scenarios for reg_scoreboard. The driver queues the expected
// outputs for each cycle. A separate monitor compares them at the falling
// edge of that cycle.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int NREG  = 32;
    localparam int LAT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             iss_en_dc, iss_long_dc, iss_en_dc_aux;
    logic [4:0]       iss_rd_dc, iss_rd_dc_aux;
    logic [LAT_W-1:0] iss_lat_dc, iss_lat_dc_aux;
    logic [4:0]       rs1_dc, rs2_dc, rs1_dc_aux, rs2_dc_aux;
    logic             rs1_vld_dc, rs2_vld_dc, rs1_vld_dc_aux, rs2_vld_dc_aux;
    logic             mdu_done;
    logic [4:0]       mdu_rd;
    logic             flush;
    logic             stall_dc, stall_dc_aux, long_busy;
    logic [NREG-1:0]  busy_vec;

    reg_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .FLUSH_AGE(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .iss_en_dc      (iss_en_dc),
        .iss_rd_dc      (iss_rd_dc),
        .iss_lat_dc     (iss_lat_dc),
        .iss_long_dc    (iss_long_dc),
        .iss_en_dc_aux  (iss_en_dc_aux),
        .iss_rd_dc_aux  (iss_rd_dc_aux),
        .iss_lat_dc_aux (iss_lat_dc_aux),
        .rs1_dc         (rs1_dc),
        .rs2_dc         (rs2_dc),
        .rs1_vld_dc     (rs1_vld_dc),
        .rs2_vld_dc     (rs2_vld_dc),
        .rs1_dc_aux     (rs1_dc_aux),
        .rs2_dc_aux     (rs2_dc_aux),
        .rs1_vld_dc_aux (rs1_vld_dc_aux),
        .rs2_vld_dc_aux (rs2_vld_dc_aux),
        .mdu_done       (mdu_done),
        .mdu_rd         (mdu_rd),
        .flush          (flush),
        .stall_dc       (stall_dc),
        .stall_dc_aux   (stall_dc_aux),
        .busy_vec       (busy_vec),
        .long_busy      (long_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic            stall;
        logic            stall_aux;
        logic [NREG-1:0] busy;
        logic            lbusy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [NREG-1:0] bit_of(input int r);
        logic [NREG-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input string field,
                         input logic [NREG-1:0] act, input logic [NREG-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: one queued expectation per checked cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.name, "stall_dc",     NREG'(stall_dc),     NREG'(e.stall));
                check(e.name, "stall_dc_aux", NREG'(stall_dc_aux), NREG'(e.stall_aux));
                check(e.name, "busy_vec",     busy_vec,            e.busy);
                check(e.name, "long_busy",    NREG'(long_busy),    NREG'(e.lbusy));
            end
        end
    end

    // Advance to the next cycle and drive idle inputs. rst is left unchanged.
    task automatic tick();
        @(posedge clk);
        #1;
        iss_en_dc      = 1'b0; iss_rd_dc     = '0; iss_lat_dc     = '0; iss_long_dc = 1'b0;
        iss_en_dc_aux  = 1'b0; iss_rd_dc_aux = '0; iss_lat_dc_aux = '0;
        rs1_dc = '0; rs2_dc = '0; rs1_vld_dc = 1'b0; rs2_vld_dc = 1'b0;
        rs1_dc_aux = '0; rs2_dc_aux = '0; rs1_vld_dc_aux = 1'b0; rs2_vld_dc_aux = 1'b0;
        mdu_done = 1'b0; mdu_rd = '0; flush = 1'b0;
    endtask

    task automatic expect_cyc(input string name, input logic s, input logic sa,
                              input logic [NREG-1:0] b, input logic l);
        exp_t e;
        e.name = name; e.stall = s; e.stall_aux = sa; e.busy = b; e.lbusy = l;
        exp_q.push_back(e);
    endtask

    task automatic main_iss(input logic [4:0] rd, input logic [LAT_W-1:0] lat, input logic lng);
        iss_en_dc = 1'b1; iss_rd_dc = rd; iss_lat_dc = lat; iss_long_dc = lng;
    endtask

    task automatic aux_iss(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
        iss_en_dc_aux = 1'b1; iss_rd_dc_aux = rd; iss_lat_dc_aux = lat;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick(); rst = 1'b1; rs1_vld_dc = 1'b1; rs1_dc = 5'd5;
        expect_cyc("reset", 0, 0, '0, 0);

        // ---------------- load-use, lat=2 ----------------
        tick(); rst = 1'b0; main_iss(5, 2, 0);
        expect_cyc("lu_issue", 0, 0, '0, 0);
        tick(); rs1_vld_dc = 1'b1; rs1_dc = 5'd5; expect_cyc("lu_c1", 1, 1, bit_of(5), 0);
        tick(); rs1_vld_dc = 1'b1; rs1_dc = 5'd5; expect_cyc("lu_c2", 1, 1, bit_of(5), 0);
        tick(); rs1_vld_dc = 1'b1; rs1_dc = 5'd5; expect_cyc("lu_c3", 0, 0, '0, 0);

        // ---------------- long-latency div ----------------
        tick(); main_iss(7, 0, 1);
        expect_cyc("div_issue", 0, 0, '0, 0);
        tick(); rs1_vld_dc = 1'b1; rs1_dc = 5'd7;
        expect_cyc("div_reader", 1, 1, bit_of(7), 1);
        tick(); main_iss(8, 0, 1);
        expect_cyc("div_second", 1, 1, bit_of(7), 1);
        for (int i = 0; i < 3; i++) begin
            tick(); rs2_vld_dc = 1'b1; rs2_dc = 5'd7;
            expect_cyc("div_wait", 1, 1, bit_of(7), 1);
        end
        tick(); mdu_done = 1'b1; mdu_rd = 5'd7; rs1_vld_dc = 1'b1; rs1_dc = 5'd7;
        expect_cyc("div_done_cyc", 1, 1, bit_of(7), 1);
        tick(); rs1_vld_dc = 1'b1; rs1_dc = 5'd7; main_iss(8, 0, 1);
        expect_cyc("div_released", 0, 0, '0, 0);
        tick(); mdu_done = 1'b1; mdu_rd = 5'd8;
        expect_cyc("div2_pending", 0, 0, bit_of(8), 1);
        tick(); expect_cyc("div2_done", 0, 0, '0, 0);

        // ---------------- same-cycle WAW, aux wins ----------------
        tick(); main_iss(9, 1, 0); aux_iss(9, 3);
        expect_cyc("waw_issue", 0, 0, '0, 0);
        tick(); rs1_vld_dc_aux = 1'b1; rs1_dc_aux = 5'd9;
        expect_cyc("waw_c1", 0, 1, bit_of(9), 0);
        tick(); expect_cyc("waw_c2", 0, 0, bit_of(9), 0);
        tick(); expect_cyc("waw_c3", 0, 0, bit_of(9), 0);
        tick(); expect_cyc("waw_c4", 0, 0, '0, 0);

        // ---------------- intra-bundle RAW ----------------
        tick(); main_iss(10, 2, 0); aux_iss(11, 1); rs2_vld_dc_aux = 1'b1; rs2_dc_aux = 5'd10;
        expect_cyc("ib_raw", 0, 1, '0, 0);
        tick(); expect_cyc("ib_c1", 0, 0, bit_of(10), 0);
        tick(); expect_cyc("ib_c2", 0, 0, bit_of(10), 0);
        tick(); expect_cyc("ib_c3", 0, 0, '0, 0);
        tick(); main_iss(12, 0, 0); rs1_vld_dc_aux = 1'b1; rs1_dc_aux = 5'd12;
        expect_cyc("ib_lat0", 0, 0, '0, 0);

        // ---------------- flush ----------------
        tick(); main_iss(4, 6, 0);
        expect_cyc("fl_x4_issue", 0, 0, '0, 0);
        tick(); expect_cyc("fl_x4_c1", 0, 0, bit_of(4), 0);
        tick(); main_iss(3, 4, 0);
        expect_cyc("fl_x3_issue", 0, 0, bit_of(4), 0);
        tick(); flush = 1'b1; main_iss(6, 3, 0);
        expect_cyc("fl_flush", 0, 0, bit_of(3) | bit_of(4), 0);
        tick(); expect_cyc("fl_after1", 0, 0, bit_of(4), 0);
        tick(); expect_cyc("fl_after2", 0, 0, bit_of(4), 0);
        tick(); expect_cyc("fl_after3", 0, 0, bit_of(4), 0);
        tick(); expect_cyc("fl_after4", 0, 0, '0, 0);

        // ---------------- x0 and invalid sources ----------------
        tick(); main_iss(0, 3, 0); aux_iss(0, 3);
        rs1_vld_dc = 1'b1; rs1_dc = 5'd0; rs2_vld_dc_aux = 1'b1; rs2_dc_aux = 5'd0;
        expect_cyc("x0_issue", 0, 0, '0, 0);
        tick(); main_iss(13, 2, 0);
        expect_cyc("x0_after", 0, 0, '0, 0);
        tick(); rs1_dc = 5'd13; rs2_dc_aux = 5'd13;
        expect_cyc("vld0_busy", 0, 0, bit_of(13), 0);
        tick(); rs2_vld_dc = 1'b1; rs2_dc = 5'd13;
        expect_cyc("vld1_busy", 1, 1, bit_of(13), 0);
        tick(); expect_cyc("vld_end", 0, 0, '0, 0);

        // ---------------- reset mid-operation ----------------
        tick(); main_iss(14, 5, 0); aux_iss(15, 4);
        expect_cyc("mr_issue1", 0, 0, '0, 0);
        tick(); main_iss(16, 7, 0);
        expect_cyc("mr_issue2", 0, 0, bit_of(14) | bit_of(15), 0);
        tick(); main_iss(17, 0, 1);
        expect_cyc("mr_issue3", 0, 0, bit_of(14) | bit_of(15) | bit_of(16), 0);
        tick(); rst = 1'b1; rs1_vld_dc = 1'b1; rs1_dc = 5'd14;
        expect_cyc("mr_rst", 0, 0, bit_of(14) | bit_of(15) | bit_of(16) | bit_of(17), 1);
        tick(); rst = 1'b0; mdu_done = 1'b1; mdu_rd = 5'd17; rs1_vld_dc = 1'b1; rs1_dc = 5'd14;
        expect_cyc("mr_cleared", 0, 0, '0, 0);
        tick(); main_iss(17, 3, 0);
        expect_cyc("mr_reissue", 0, 0, '0, 0);
        tick(); mdu_done = 1'b1; mdu_rd = 5'd17;
        expect_cyc("stale_done", 0, 0, bit_of(17), 0);
        tick(); expect_cyc("stale_c2", 0, 0, bit_of(17), 0);
        tick(); expect_cyc("stale_c3", 0, 0, bit_of(17), 0);
        tick(); expect_cyc("stale_end", 0, 0, '0, 0);

        // ---------------- issue beats same-cycle mdu_done ----------------
        tick(); main_iss(18, 0, 1);
        expect_cyc("iw_div", 0, 0, '0, 0);
        tick(); mdu_done = 1'b1; mdu_rd = 5'd18; main_iss(18, 2, 0);
        expect_cyc("iw_race", 0, 0, bit_of(18), 1);
        tick(); expect_cyc("iw_c1", 0, 0, bit_of(18), 0);
        tick(); expect_cyc("iw_c2", 0, 0, bit_of(18), 0);
        tick(); expect_cyc("iw_c3", 0, 0, '0, 0);

        // Let the monitor drain, with a bound.
        tick();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
